// File: rtl/cla_chk_pkg.sv
// Shared definitions for the CLA response checker: FSM states, default
// widths and the packed vector record used by the stage register and the
// first-failure record.
package cla_chk_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One observed vector: operands and carry-in applied to the adder, plus
  // the adder's reported sum and carry-out.
  typedef struct packed {
    logic [DEF_W-1:0] a;
    logic [DEF_W-1:0] b;
    logic             cin;
    logic [DEF_W-1:0] sum;
    logic             cout;
  } vec_t;

endpackage

// File: rtl/cla_golden_add.sv
// Reference adder: (W+1)-bit unsigned result of a + b + cin.
module cla_golden_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W:0]   res_o
);

  assign res_o = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/cla_response_checker.sv
// Response checker for the 4-bit CLA adder. Accepts {a, b, cin, sum, cout}
// over valid/ready, recomputes the golden sum one stage later, and keeps
// saturating vector / error counters plus a first-failure record.
// Optional build macro CLA_CHK_TMR_EN: triplicated golden adder with a
// bitwise majority vote and a sticky gold_fault output.
module cla_response_checker
  import cla_chk_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  input  logic [W-1:0]     in_sum,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic             fail_cin,
  output logic [W-1:0]     fail_sum,
`ifdef CLA_CHK_TMR_EN
  output logic             fail_cout,
  output logic             gold_fault
`else
  output logic             fail_cout
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, acc_cnt_q, vec_cnt_q, err_cnt_q;
  vec_t             s1_q, fail_q;
  logic             s1_valid_q, fail_valid_q;
  logic             accept, start_ok, last_accept, mismatch;
  logic [W:0]       gold_res;

  assign accept      = in_valid && (state_q == RUN);
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == num_vec_q);
  assign mismatch    = (gold_res != {s1_q.cout, s1_q.sum});

`ifdef CLA_CHK_TMR_EN
  logic [W:0] gold_copy [3];
  logic       gold_disagree;
  logic       gold_fault_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_gold
    cla_golden_add #(.W(W)) u_add (
      .a_i(s1_q.a), .b_i(s1_q.b), .cin_i(s1_q.cin), .res_o(gold_copy[gi])
    );
  end

  assign gold_res = (gold_copy[0] & gold_copy[1]) |
                    (gold_copy[1] & gold_copy[2]) |
                    (gold_copy[0] & gold_copy[2]);
  assign gold_disagree = (gold_copy[0] != gold_copy[1]) ||
                         (gold_copy[1] != gold_copy[2]);
  assign gold_fault = gold_fault_q;

  // Sticky flag: any vote disagreement during a run, cleared by a new run.
  always_ff @(posedge clk) begin
    if (rst || start_ok) gold_fault_q <= 1'b0;
    else if (s1_valid_q && gold_disagree) gold_fault_q <= 1'b1;
  end
`else
  cla_golden_add #(.W(W)) u_add (
    .a_i(s1_q.a), .b_i(s1_q.b), .cin_i(s1_q.cin), .res_o(gold_res)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: DRAIN holds until the compare stage has retired the last vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_vec == '0) ? DONE : RUN;
      RUN:        if (last_accept) state_d = DRAIN;
      DRAIN:      if (!s1_valid_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    pass     = (state_q == DONE) && (err_cnt_q == '0);
  end

  // Stage 1 capture, stage 2 compare, counters and first-failure record.
  // Reset clears s1_valid_q so an in-flight vector is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      num_vec_q    <= '0;
      acc_cnt_q    <= '0;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_q <= '{a: in_a, b: in_b, cin: in_cin, sum: in_sum, cout: in_cout};
      if (start_ok) begin
        num_vec_q    <= num_vec;
        acc_cnt_q    <= '0;
        vec_cnt_q    <= '0;
        err_cnt_q    <= '0;
        fail_valid_q <= 1'b0;
        fail_q       <= '0;
      end else begin
        if (accept) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (s1_valid_q) begin
          if (vec_cnt_q != CNT_MAX) vec_cnt_q <= vec_cnt_q + CNT_W'(1);
          if (mismatch) begin
            if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_q       <= s1_q;
            end
          end
        end
      end
    end
  end

  assign vec_cnt    = vec_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_q.a;
  assign fail_b     = fail_q.b;
  assign fail_cin   = fail_q.cin;
  assign fail_sum   = fail_q.sum;
  assign fail_cout  = fail_q.cout;

endmodule
